// File: rtl/ppu_writer.sv
// ppu_writer: host-side write initiator for the sprite PPU register interface.
//
// Attribute, sprite-bitmap and color-table updates from a producer are queued
// in a FIFO. Only entries up to the newest batch boundary (in_last) are
// released, and only while vcount is in vertical blanking. Because of this,
// the PPU tables never change in the middle of a visible frame.
//
// Ports:
//   clk, reset            clock; synchronous active-high reset
//   in_valid/in_ready     producer handshake (see below)
//   in_addr, in_data      PPU address / data; in_addr[9:8] selects the table
//                         (00 attr, 01 sprite, 10 color, 11 illegal)
//   in_last               entry closes a batch (commit point)
//   vcount                current VGA line, shared with the PPU
//   chipselect, write     PPU strobes, high together for one cycle per write
//   address, writedata    PPU write address / data; hold when idle
//   level                 entries currently held in the FIFO
//   err                   sticky: an illegal-table entry was discarded
//   frame_done            1-cycle pulse with the write that drains the
//                         committed work
//   state_dbg             current drain FSM state (WAIT=0, DRAIN=1, DONE=2)
//
// Handshake: an entry transfers on a rising clk edge where in_valid && in_ready.
// in_ready depends only on the registered fill count (never on in_valid), so a
// producer may hold in_valid high and wait for in_ready with stable payload.
module ppu_writer #(
  parameter int DEPTH   = 32,
  parameter int VACTIVE = 480,
  parameter int GAP     = 0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [15:0]              in_addr,
  input  logic [31:0]              in_data,
  input  logic                     in_last,
  input  logic [9:0]               vcount,
  output logic                     chipselect,
  output logic                     write,
  output logic [15:0]              address,
  output logic [31:0]              writedata,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     err,
  output logic                     frame_done,
  output logic [1:0]               state_dbg
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    ST_WAIT  = 2'd0,
    ST_DRAIN = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t state, state_next;

  logic [15:0]  addr_mem [DEPTH];
  logic [31:0]  data_mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   cnt, cnt_next;
  logic [AW:0]   committed, committed_next;
  logic [2:0]    gap_cnt;

  logic vblank;
  logic full;
  logic push;
  logic pop;
  logic pop_ok;
  logic drain_done;
  logic head_illegal;

  assign vblank       = (vcount >= 10'(VACTIVE));
  assign full         = (cnt == (AW+1)'(DEPTH));
  assign in_ready     = !full;
  assign push         = in_valid && in_ready;
  assign head_illegal = (addr_mem[rd_ptr][9:8] == 2'b11);
  assign pop_ok       = vblank && (committed != '0) && (gap_cnt == 3'd0);
  assign level        = cnt;
  assign state_dbg    = state;

  // This pop empties the committed set, unless a new batch closes in the same
  // cycle (that batch then re-loads committed with a non-zero count).
  assign drain_done = pop && (committed == (AW+1)'(1)) && !(push && in_last);

  // Next-state / pop decision
  always_comb begin
    state_next = state;
    pop        = 1'b0;
    case (state)
      ST_WAIT: begin
        if (vblank && (committed != '0)) state_next = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (!vblank) begin
          state_next = ST_WAIT;
        end else if (pop_ok) begin
          pop = 1'b1;
          if (drain_done) state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        // Late commits in the same blanking are drained from here.
        if (!vblank) begin
          state_next = ST_WAIT;
        end else if (pop_ok) begin
          pop = 1'b1;
        end
      end
      default: state_next = ST_WAIT;
    endcase
  end

  // Fill count and committed count
  always_comb begin
    cnt_next = cnt;
    case ({push, pop})
      2'b10:   cnt_next = cnt + 1'b1;
      2'b01:   cnt_next = cnt - 1'b1;
      default: cnt_next = cnt;
    endcase

    committed_next = committed;
    if (push && in_last) begin
      committed_next = cnt_next;
    end else if (pop) begin
      committed_next = committed - 1'b1;
    end
  end

  // FIFO storage: no reset needed, validity is tracked by cnt.
  always_ff @(posedge clk) begin
    if (push) begin
      addr_mem[wr_ptr] <= in_addr;
      data_mem[wr_ptr] <= in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_WAIT;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      cnt        <= '0;
      committed  <= '0;
      gap_cnt    <= 3'd0;
      chipselect <= 1'b0;
      write      <= 1'b0;
      address    <= 16'h0000;
      writedata  <= 32'h0000_0000;
      err        <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state     <= state_next;
      cnt       <= cnt_next;
      committed <= committed_next;

      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;

      // Spacing applies after every pop, including discarded entries.
      if (pop) begin
        gap_cnt <= 3'(GAP);
      end else if (gap_cnt != 3'd0) begin
        gap_cnt <= gap_cnt - 3'd1;
      end

      chipselect <= pop && !head_illegal;
      write      <= pop && !head_illegal;
      if (pop && !head_illegal) begin
        address   <= addr_mem[rd_ptr];
        writedata <= data_mem[rd_ptr];
      end
      if (pop && head_illegal) err <= 1'b1;

      frame_done <= drain_done;
    end
  end

endmodule
